openfire_alu: RTL and testbench
===============================

// Module: openfire_alu
// PURPOSE
//  - Combinational datapath ALU of the OpenFire EXECUTE stage, plus a registered multi-cycle multiply.
//  - Also produces the data-memory address (adder output) and a carry-out for the MSR C bit.
//  - Instantiates openfire_compare, the branch/CMPU condition evaluator.
//  - Operand inversion (subtract, ANDN) and carry-in selection happen upstream in EXECUTE.
// PARAMETERS
//  - D_WIDTH  32  datapath width (16 or 32)
// PORTS
//  clock                          in   1        single clock, rising edge
//  reset                          in   1        synchronous, active-low (asserted when 0)
//  stall                          in   1        pipeline stall; freezes all internal state
//  a                              in   D_WIDTH  operand A (already inverted/selected)
//  b                              in   D_WIDTH  operand B
//  c_in                           in   1        adder carry-in
//  fns                            in   4        ALU function select
//  alu_result                     out  D_WIDTH  result
//  c_out                          out  1        carry/shift-out bit
//  dmem_addr                      out  32       adder sum, zero-extended to 32 bits
//  alu_multicycle_instr           out  1        high while fns==ALU_multiply
//  alu_multicycle_instr_complete  out  1        registered multiply-done strobe
//  cmp_in0, cmp_in1               in   D_WIDTH  comparator operands (rA, rB)
//  cmp_fns                        in   3        comparator function
//  cmp_out                        out  1        comparator result
// BEHAVIOUR
//  - sum = a + b + c_in, computed D_WIDTH+1 bits wide; dmem_addr = sum[D_WIDTH-1:0] for every fns.
//  - fns encodings:
//      0 ADD: result = sum, c_out = sum[D_WIDTH]
//      1 OR: a|b
//      2 AND: a&b
//      3 XOR: a^b
//      4 SEXT8: {sign a[7]}, a[7:0}
//      5 SEXT16: {sign a[15]}, a[15:0]
//      6 SRA: {a[MSB], a[MSB:1]}
//      7 SRL: {0, a[MSB:1]}
//      8 SRC: {c_in, a[MSB:1]}
//      9 COMPARE: result = sum
//      10 COMPARE_UNS: result = sum
//      11 MULTIPLY: result = product register
//      12-15: result 0
//  - c_out: sum carry for ADD/COMPARE/COMPARE_UNS; a[0] for shifts (6-8); 0 otherwise.
//  - alu_result and c_out are purely combinational (0-cycle) except MULTIPLY.
//  - MULTIPLY: on each non-stalled edge, prod <= low D_WIDTH bits of a*b.
//  - complete flag, updated on non-stalled edges only:
//      if fns==MUL && complete: complete <= 0 (back-to-back MULs re-arm)
//      else: complete <= (fns==MUL)
//  - Net effect: a single MUL completes 1 cycle after issue; result is valid while complete=1.
//  - stall=1: prod and complete hold their values.
//  - reset=0 at a clock edge: prod=0, complete=0; reset has priority over stall.
//  - Mid-multiply reset aborts the operation; no completion strobe follows.
//  - openfire_compare (combinational), cmp_fns:
//      0 in0==0
//      1 in0!=0
//      2 in0<0 (signed)
//      3 in0<=0
//      4 in0>0
//      5 in0>=0
//      6 constant 1 (unconditional branch)
//      7 in0>in1 (unsigned; MSB of CMPU)
//  - Overflow wraps silently; no exceptions raised.
// STRUCTURE
//  - Shared package/include: D_WIDTH, ALU_* fns codes (0-11), CMP_* codes (0-7).
//  - One sub-module: openfire_compare(in0, in1, fns, out); the ALU instantiates it once and wires cmp_* through.
// TESTING
//  - ADD a=32'hFFFFFFFF, b=1, c_in=0 -> result 0, c_out 1, dmem_addr 0.
//    SUB via a=~5, b=9, c_in=1 -> result 4, c_out 1.
//  - SRA a=32'h80000003 -> 32'hC0000001, c_out 1.
//    SRL same a -> 32'h40000001.
//    SRC with c_in=1, a=2 -> 32'h80000001, c_out 0.
//  - SEXT8 a=32'h000000F0 -> 32'hFFFFFFF0.
//    SEXT16 a=32'h00007FFF -> 32'h00007FFF.
//    XOR a=b -> 0.
//  - MUL a=7, b=6: complete 0 on the issue cycle, 1 one edge later with result 42.
//    Second MUL held on fns toggles complete 1->0->1.
//    stall=1 freezes complete.
//    reset=0 mid-operation -> complete 0.
//  - Compare in0=0: fns0=1, fns5=1, fns2=0.
//    in0=32'h80000000: fns2=1, fns4=0.
//    fns6=1 always.
//    fns7: in0=32'hFFFFFFFF, in1=1 -> 1; swapped -> 0.

Source files
------------

// File: rtl/openfire_alu_pkg.sv
// Shared constants for the OpenFire EXECUTE-stage ALU and branch comparator.
package openfire_alu_pkg;

    localparam int D_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_ADD         = 4'd0,
        ALU_OR          = 4'd1,
        ALU_AND         = 4'd2,
        ALU_XOR         = 4'd3,
        ALU_SEXT8       = 4'd4,
        ALU_SEXT16      = 4'd5,
        ALU_SHIFT_SRA   = 4'd6,
        ALU_SHIFT_SRL   = 4'd7,
        ALU_SHIFT_SRC   = 4'd8,
        ALU_COMPARE     = 4'd9,
        ALU_COMPARE_UNS = 4'd10,
        ALU_MULTIPLY    = 4'd11
    } alu_fns_e;

    typedef enum logic [2:0] {
        CMP_EQ_ZERO = 3'd0,
        CMP_NE_ZERO = 3'd1,
        CMP_LT_ZERO = 3'd2,
        CMP_LE_ZERO = 3'd3,
        CMP_GT_ZERO = 3'd4,
        CMP_GE_ZERO = 3'd5,
        CMP_ALWAYS  = 3'd6,
        CMP_GT_UNS  = 3'd7
    } cmp_fns_e;

endpackage

// File: rtl/openfire_alu_compare.sv
// Branch / CMPU condition evaluator: tests rA against zero, or rA > rB unsigned.
module openfire_compare
    import openfire_alu_pkg::*;
#(
    parameter int D_WIDTH = openfire_alu_pkg::D_WIDTH
) (
    input  logic [D_WIDTH-1:0] in0,
    input  logic [D_WIDTH-1:0] in1,
    input  logic [2:0]         fns,
    output logic               out
);

    logic is_zero;
    logic is_neg;

    assign is_zero = (in0 == '0);
    assign is_neg  = in0[D_WIDTH-1];

    // NOTE: a default assignment before the case keeps every path driven, so no latch is inferred.
    always_comb begin
        out = 1'b0;
        case (fns)
            CMP_EQ_ZERO: out = is_zero;
            CMP_NE_ZERO: out = !is_zero;
            CMP_LT_ZERO: out = is_neg;
            CMP_LE_ZERO: out = is_neg || is_zero;
            CMP_GT_ZERO: out = !is_neg && !is_zero;
            CMP_GE_ZERO: out = !is_neg;
            CMP_ALWAYS:  out = 1'b1;
            CMP_GT_UNS:  out = (in0 > in1);
            default:     out = 1'b0;
        endcase
    end

endmodule

// File: rtl/openfire_alu.sv
// OpenFire EXECUTE-stage ALU: combinational datapath, data-memory address adder,
// registered single-cycle-latency multiply and the branch comparator.
module openfire_alu
    import openfire_alu_pkg::*;
#(
    parameter int D_WIDTH = openfire_alu_pkg::D_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic [D_WIDTH-1:0] a,
    input  logic [D_WIDTH-1:0] b,
    input  logic               c_in,
    input  logic [3:0]         fns,
    output logic [D_WIDTH-1:0] alu_result,
    output logic               c_out,
    output logic [31:0]        dmem_addr,
    output logic               alu_multicycle_instr,
    output logic               alu_multicycle_instr_complete,
    input  logic [D_WIDTH-1:0] cmp_in0,
    input  logic [D_WIDTH-1:0] cmp_in1,
    input  logic [2:0]         cmp_fns,
    output logic               cmp_out
);

    logic [D_WIDTH:0]   sum;
    logic [D_WIDTH-1:0] mul_lo;
    logic [D_WIDTH-1:0] prod;
    logic               complete;
    logic               is_mul;

    assign sum       = {1'b0, a} + {1'b0, b} + {{D_WIDTH{1'b0}}, c_in};
    assign dmem_addr = 32'(sum[D_WIDTH-1:0]);
    assign mul_lo    = a * b;
    assign is_mul    = (fns == ALU_MULTIPLY);

    assign alu_multicycle_instr          = is_mul;
    assign alu_multicycle_instr_complete = complete;

    always_comb begin
        alu_result = '0;
        c_out      = 1'b0;
        case (fns)
            ALU_ADD, ALU_COMPARE, ALU_COMPARE_UNS: begin
                alu_result = sum[D_WIDTH-1:0];
                c_out      = sum[D_WIDTH];
            end
            ALU_OR:     alu_result = a | b;
            ALU_AND:    alu_result = a & b;
            ALU_XOR:    alu_result = a ^ b;
            ALU_SEXT8:  alu_result = D_WIDTH'($signed(a[7:0]));
            ALU_SEXT16: alu_result = D_WIDTH'($signed(a[15:0]));
            ALU_SHIFT_SRA: begin
                alu_result = {a[D_WIDTH-1], a[D_WIDTH-1:1]};
                c_out      = a[0];
            end
            ALU_SHIFT_SRL: begin
                alu_result = {1'b0, a[D_WIDTH-1:1]};
                c_out      = a[0];
            end
            ALU_SHIFT_SRC: begin
                alu_result = {c_in, a[D_WIDTH-1:1]};
                c_out      = a[0];
            end
            ALU_MULTIPLY: alu_result = prod;
            default:      alu_result = '0;
        endcase
    end

    // Holding MUL re-arms the strobe every other cycle so back-to-back multiplies each complete.
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            prod     <= '0;
            complete <= 1'b0;
        end else if (!stall) begin
            prod     <= mul_lo;
            complete <= is_mul && !complete;
        end
    end

    openfire_compare #(
        .D_WIDTH(D_WIDTH)
    ) u_compare (
        .in0(cmp_in0),
        .in1(cmp_in1),
        .fns(cmp_fns),
        .out(cmp_out)
    );

endmodule

// File: tb/tb_openfire_alu.sv
// Directed self-checking bench for openfire_alu: datapath functions, multiply handshake, comparator.
module tb_openfire_alu;
    import openfire_alu_pkg::*;

    logic        clock;
    logic        reset;
    logic        stall;
    logic [31:0] a;
    logic [31:0] b;
    logic        c_in;
    logic [3:0]  fns;
    logic [31:0] alu_result;
    logic        c_out;
    logic [31:0] dmem_addr;
    logic        alu_multicycle_instr;
    logic        alu_multicycle_instr_complete;
    logic [31:0] cmp_in0;
    logic [31:0] cmp_in1;
    logic [2:0]  cmp_fns;
    logic        cmp_out;

    int tests;
    int fails;

    openfire_alu dut (
        .clock(clock),
        .reset(reset),
        .stall(stall),
        .a(a),
        .b(b),
        .c_in(c_in),
        .fns(fns),
        .alu_result(alu_result),
        .c_out(c_out),
        .dmem_addr(dmem_addr),
        .alu_multicycle_instr(alu_multicycle_instr),
        .alu_multicycle_instr_complete(alu_multicycle_instr_complete),
        .cmp_in0(cmp_in0),
        .cmp_in1(cmp_in1),
        .cmp_fns(cmp_fns),
        .cmp_out(cmp_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then sample/drive 1 ns later, away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic op(input logic [3:0] f, input logic [31:0] va, input logic [31:0] vb,
                      input logic ci);
        fns  = f;
        a    = va;
        b    = vb;
        c_in = ci;
        #1;
    endtask

    task automatic cmp(input logic [2:0] f, input logic [31:0] i0, input logic [31:0] i1);
        cmp_fns = f;
        cmp_in0 = i0;
        cmp_in1 = i1;
        #1;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset   = 1'b0;
        stall   = 1'b0;
        a       = 32'd7;
        b       = 32'd6;
        c_in    = 1'b0;
        fns     = ALU_MULTIPLY;
        cmp_in0 = '0;
        cmp_in1 = '0;
        cmp_fns = CMP_ALWAYS;

        tick();
        tick();
        check("reset_complete", {31'd0, alu_multicycle_instr_complete}, 32'd0);
        check("reset_prod", alu_result, 32'd0);
        check("multicycle_flag", {31'd0, alu_multicycle_instr}, 32'd1);
        reset = 1'b1;
        fns   = ALU_ADD;
        tick();

        op(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
        check("add_wrap_res", alu_result, 32'd0);
        check("add_wrap_cout", {31'd0, c_out}, 32'd1);
        check("add_wrap_addr", dmem_addr, 32'd0);
        check("add_multicycle_flag", {31'd0, alu_multicycle_instr}, 32'd0);

        op(ALU_ADD, ~32'd5, 32'd9, 1'b1);
        check("sub_res", alu_result, 32'd4);
        check("sub_cout", {31'd0, c_out}, 32'd1);

        op(ALU_OR, 32'd3, 32'd5, 1'b0);
        check("or_res", alu_result, 32'd7);
        check("or_addr", dmem_addr, 32'd8);
        check("or_cout", {31'd0, c_out}, 32'd0);

        op(ALU_AND, 32'hC, 32'hA, 1'b0);
        check("and_res", alu_result, 32'h8);

        op(ALU_XOR, 32'h1234_5678, 32'h1234_5678, 1'b0);
        check("xor_same", alu_result, 32'd0);

        op(ALU_XOR, 32'hF0F0_0000, 32'h0FF0_0001, 1'b0);
        check("xor_mixed", alu_result, 32'hFF00_0001);

        op(ALU_SHIFT_SRA, 32'h8000_0003, 32'd0, 1'b0);
        check("sra_res", alu_result, 32'hC000_0001);
        check("sra_cout", {31'd0, c_out}, 32'd1);

        op(ALU_SHIFT_SRL, 32'h8000_0003, 32'd0, 1'b0);
        check("srl_res", alu_result, 32'h4000_0001);
        check("srl_cout", {31'd0, c_out}, 32'd1);

        op(ALU_SHIFT_SRC, 32'd2, 32'd0, 1'b1);
        check("src_res", alu_result, 32'h8000_0001);
        check("src_cout", {31'd0, c_out}, 32'd0);

        op(ALU_SEXT8, 32'h0000_00F0, 32'd0, 1'b0);
        check("sext8_neg", alu_result, 32'hFFFF_FFF0);

        op(ALU_SEXT16, 32'h0000_7FFF, 32'd0, 1'b0);
        check("sext16_pos", alu_result, 32'h0000_7FFF);

        op(ALU_SEXT16, 32'h1234_8001, 32'd0, 1'b0);
        check("sext16_neg", alu_result, 32'hFFFF_8001);

        op(ALU_COMPARE, ~32'd3, 32'd10, 1'b1);
        check("compare_res", alu_result, 32'd7);
        check("compare_cout", {31'd0, c_out}, 32'd1);

        op(ALU_COMPARE_UNS, ~32'd10, 32'd3, 1'b1);
        check("compare_uns_res", alu_result, 32'hFFFF_FFF9);
        check("compare_uns_cout", {31'd0, c_out}, 32'd0);

        op(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check("unused_res", alu_result, 32'd0);
        check("unused_cout", {31'd0, c_out}, 32'd0);
        check("unused_addr", dmem_addr, 32'hFFFF_FFFF);

        // Multiply handshake
        tick();
        op(ALU_MULTIPLY, 32'd7, 32'd6, 1'b0);
        check("mul_issue_complete", {31'd0, alu_multicycle_instr_complete}, 32'd0);
        tick();
        check("mul_done_complete", {31'd0, alu_multicycle_instr_complete}, 32'd1);
        check("mul_done_res", alu_result, 32'd42);
        tick();
        check("mul_rearm_0", {31'd0, alu_multicycle_instr_complete}, 32'd0);
        tick();
        check("mul_rearm_1", {31'd0, alu_multicycle_instr_complete}, 32'd1);

        stall = 1'b1;
        a     = 32'd3;
        b     = 32'd3;
        tick();
        check("stall_complete", {31'd0, alu_multicycle_instr_complete}, 32'd1);
        check("stall_prod", alu_result, 32'd42);
        stall = 1'b0;
        tick();
        check("unstall_complete", {31'd0, alu_multicycle_instr_complete}, 32'd0);
        check("unstall_prod", alu_result, 32'd9);

        op(ALU_MULTIPLY, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        reset = 1'b0;
        tick();
        check("abort_complete", {31'd0, alu_multicycle_instr_complete}, 32'd0);
        check("abort_prod", alu_result, 32'd0);
        reset = 1'b1;
        fns   = ALU_ADD;
        tick();
        check("abort_no_strobe", {31'd0, alu_multicycle_instr_complete}, 32'd0);

        fns = ALU_MULTIPLY;
        tick();
        check("wrap_mul_complete", {31'd0, alu_multicycle_instr_complete}, 32'd1);
        check("wrap_mul_res", alu_result, 32'd1);
        stall = 1'b1;
        reset = 1'b0;
        tick();
        check("reset_over_stall", {31'd0, alu_multicycle_instr_complete}, 32'd0);
        check("reset_over_stall_prod", alu_result, 32'd0);
        stall = 1'b0;
        reset = 1'b1;

        // Comparator
        cmp(CMP_EQ_ZERO, 32'd0, 32'd0);
        check("cmp_eq_zero", {31'd0, cmp_out}, 32'd1);
        cmp(CMP_GE_ZERO, 32'd0, 32'd0);
        check("cmp_ge_zero", {31'd0, cmp_out}, 32'd1);
        cmp(CMP_LT_ZERO, 32'd0, 32'd0);
        check("cmp_lt_zero", {31'd0, cmp_out}, 32'd0);
        cmp(CMP_NE_ZERO, 32'd5, 32'd0);
        check("cmp_ne_nonzero", {31'd0, cmp_out}, 32'd1);
        cmp(CMP_LT_ZERO, 32'h8000_0000, 32'd0);
        check("cmp_lt_min", {31'd0, cmp_out}, 32'd1);
        cmp(CMP_GT_ZERO, 32'h8000_0000, 32'd0);
        check("cmp_gt_min", {31'd0, cmp_out}, 32'd0);
        cmp(CMP_LE_ZERO, 32'h8000_0000, 32'd0);
        check("cmp_le_min", {31'd0, cmp_out}, 32'd1);
        cmp(CMP_GT_ZERO, 32'd1, 32'd0);
        check("cmp_gt_one", {31'd0, cmp_out}, 32'd1);
        cmp(CMP_ALWAYS, 32'h8000_0000, 32'd9);
        check("cmp_always", {31'd0, cmp_out}, 32'd1);
        cmp(CMP_GT_UNS, 32'hFFFF_FFFF, 32'd1);
        check("cmp_gt_uns", {31'd0, cmp_out}, 32'd1);
        cmp(CMP_GT_UNS, 32'd1, 32'hFFFF_FFFF);
        check("cmp_gt_uns_swap", {31'd0, cmp_out}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
